// File: rtl/lsm_sequencer_if.sv
// lsm_sequencer_if: CU/memory-side handshake bundle for the LDM/STM sequencer.
//   master : CU + memory model; drives start/reg_list/p/u/base/moc.
//   slave  : the sequencer; drives mfa/mar_addr/reg_sel/xfer/busy/lsm_end/abort/wb_addr.
interface lsm_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [15:0]       reg_list;
  logic              p;
  logic              u;
  logic [ADDR_W-1:0] base;
  logic              moc;
  logic              mfa;
  logic [ADDR_W-1:0] mar_addr;
  logic [3:0]        reg_sel;
  logic              xfer;
  logic              busy;
  logic              lsm_end;
  logic              abort;
  logic [ADDR_W-1:0] wb_addr;

  modport master (
    output start, reg_list, p, u, base, moc,
    input  mfa, mar_addr, reg_sel, xfer, busy, lsm_end, abort, wb_addr
  );

  modport slave (
    input  start, reg_list, p, u, base, moc,
    output mfa, mar_addr, reg_sel, xfer, busy, lsm_end, abort, wb_addr
  );
endinterface

// File: rtl/lsm_sequencer.sv
// lsm_sequencer: walks an LDM/STM register list in ascending order, issuing one
// MFA/MOC memory handshake per word and reporting completion plus the
// write-back base to the control unit.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : lsm_sequencer_if.slave (request in, memory handshake, status out)
// Parameters:
//   ADDR_W      : address/base width
//   MOC_TIMEOUT : ACCESS cycles allowed without MOC before aborting; 0 = wait forever
module lsm_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int MOC_TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           reset,
  lsm_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, NEXT, DONE} state_t;

  state_t            state;
  logic [15:0]       list_q;    // registers still to transfer
  logic [ADDR_W-1:0] addr_q;    // address of the next word
  logic [31:0]       wait_cnt;  // ACCESS cycles spent waiting on MOC

  logic [4:0]        n_in;
  logic [ADDR_W-1:0] off_in;
  logic [ADDR_W-1:0] start_addr;
  logic [3:0]        lo_idx;

  // Word count and byte offset of the incoming request. WB and the first
  // address are captured along with START so WB is already valid in SETUP.
  always_comb begin
    n_in = '0;
    for (int i = 0; i < 16; i++) n_in = n_in + 5'(bus.reg_list[i]);
  end

  assign off_in = ADDR_W'(n_in) << 2;

  always_comb begin
    case ({bus.p, bus.u})
      2'b01:   start_addr = bus.base;                            // IA
      2'b11:   start_addr = bus.base + ADDR_W'(4);               // IB
      2'b00:   start_addr = bus.base - off_in + ADDR_W'(4);      // DA
      default: start_addr = bus.base - off_in;                   // DB
    endcase
  end

  // Lowest remaining register; transfers always go in ascending order.
  always_comb begin
    lo_idx = '0;
    for (int i = 15; i >= 0; i--) if (list_q[i]) lo_idx = 4'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      list_q       <= '0;
      addr_q       <= '0;
      wait_cnt     <= '0;
      bus.mfa      <= 1'b0;
      bus.mar_addr <= '0;
      bus.reg_sel  <= '0;
      bus.xfer     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.lsm_end  <= 1'b0;
      bus.abort    <= 1'b0;
      bus.wb_addr  <= '0;
    end else begin
      bus.xfer    <= 1'b0;
      bus.lsm_end <= 1'b0;
      bus.abort   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            list_q      <= bus.reg_list;
            addr_q      <= start_addr;
            wait_cnt    <= '0;
            bus.wb_addr <= bus.u ? bus.base + off_in : bus.base - off_in;
            bus.busy    <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (list_q == '0) begin
            bus.lsm_end <= 1'b1;
            state       <= DONE;
          end else begin
            bus.mfa      <= 1'b1;
            bus.reg_sel  <= lo_idx;
            bus.mar_addr <= addr_q;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.moc) begin
            // Retire the word on the way into NEXT; reg_sel/mar_addr keep
            // showing it while the list and address move on underneath.
            bus.mfa  <= 1'b0;
            bus.xfer <= 1'b1;
            list_q   <= list_q & (list_q - 16'd1);
            addr_q   <= addr_q + ADDR_W'(4);
            wait_cnt <= '0;
            state    <= NEXT;
          end else if (MOC_TIMEOUT > 0 && wait_cnt == 32'(MOC_TIMEOUT - 1)) begin
            bus.mfa     <= 1'b0;
            bus.lsm_end <= 1'b1;
            bus.abort   <= 1'b1;
            state       <= DONE;
          end else if (MOC_TIMEOUT > 0) begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        NEXT: begin
          if (list_q == '0) begin
            bus.lsm_end <= 1'b1;
            state       <= DONE;
          end else begin
            bus.mfa      <= 1'b1;
            bus.reg_sel  <= lo_idx;
            bus.mar_addr <= addr_q;
            state        <= ACCESS;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsm_sequencer.sv
// tb_lsm_sequencer: scoreboard bench for lsm_sequencer. Each request pushes its
// expected words and completion record; a negedge monitor pops and compares.
module tb_lsm_sequencer;
  localparam int MOC_TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsm_sequencer_if #(.ADDR_W(32)) ifc ();

  lsm_sequencer #(.ADDR_W(32), .MOC_TIMEOUT(MOC_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct {logic [3:0] r; logic [31:0] a;} word_t;
  typedef struct {logic [31:0] wb; logic ab; int c; int left;} end_t;

  word_t word_q[$];
  end_t  end_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Memory model: hold MOC low for 'stall' ACCESS cycles, then complete.
  initial begin
    int acc;
    acc = 0;
    ifc.moc = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.mfa) begin
        ifc.moc = (acc >= stall);
        acc++;
      end else begin
        ifc.moc = 1'b0;
        acc = 0;
      end
    end
  end

  // Monitor
  initial begin
    end_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ifc.mfa) begin
          chk("mfa_expected", word_q.size() != 0, 1);
          if (word_q.size() != 0) begin
            chk("acc_reg_sel", ifc.reg_sel, word_q[0].r);
            chk("acc_addr", ifc.mar_addr, word_q[0].a);
          end
        end
        if (ifc.xfer) begin
          chk("xfer_expected", word_q.size() != 0, 1);
          chk("xfer_mfa", ifc.mfa, 0);
          if (word_q.size() != 0) begin
            chk("xfer_reg_sel", ifc.reg_sel, word_q[0].r);
            chk("xfer_addr", ifc.mar_addr, word_q[0].a);
            void'(word_q.pop_front());
          end
        end
        if (ifc.lsm_end) begin
          chk("end_expected", end_q.size() != 0, 1);
          if (end_q.size() != 0) begin
            e = end_q.pop_front();
            chk("end_wb", ifc.wb_addr, e.wb);
            chk("end_abort", ifc.abort, e.ab);
            chk("end_cycle", cyc, e.c);
            chk("end_words_left", word_q.size(), e.left);
            chk("end_busy", ifc.busy, 1);
          end
          word_q.delete();
          done_cnt++;
        end
        if (ifc.abort && !ifc.lsm_end) chk("abort_with_end", ifc.lsm_end, 1);
      end
    end
  end

  // Push the expected words + completion, issue START, wait for LSM_END.
  task automatic run(input logic [15:0] list, input logic p, input logic u,
                     input logic [31:0] base, input int stl, input bit ab, input bit glitch);
    int n, t0, d0;
    logic [31:0] off, a, wb;
    end_t e;
    n   = $countones(list);
    off = 32'(n * 4);
    case ({p, u})
      2'b01:   a = base;
      2'b11:   a = base + 32'd4;
      2'b00:   a = base - off + 32'd4;
      default: a = base - off;
    endcase
    wb = u ? base + off : base - off;
    stall = stl;
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.reg_list = list; ifc.p = p; ifc.u = u; ifc.base = base;
    t0 = cyc; d0 = done_cnt;
    for (int i = 0; i < 16; i++)
      if (list[i]) begin
        word_q.push_back('{r: 4'(i), a: a});
        a = a + 32'd4;
      end
    e.wb = wb; e.ab = ab;
    e.c = ab ? t0 + 2 + MOC_TO : t0 + 2 + n * (2 + stl);
    e.left = ab ? n : 0;
    end_q.push_back(e);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk("setup_busy", ifc.busy, 1);
    chk("setup_wb", ifc.wb_addr, wb);
    chk("setup_mfa", ifc.mfa, 0);
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      if (glitch && i == 2) begin
        ifc.start = 1'b1; ifc.reg_list = 16'hFFFF; ifc.base = ~base; ifc.p = ~p;
      end else ifc.start = 1'b0;
      @(posedge clk); #1;
    end
    ifc.start = 1'b0;
    chk("end_count", done_cnt - d0, 1);
    chk("idle_busy", ifc.busy, 0);
    chk("idle_mfa", ifc.mfa, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.start = 1'b0; ifc.reg_list = '0; ifc.p = 1'b0; ifc.u = 1'b0; ifc.base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mfa", ifc.mfa, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_xfer", ifc.xfer, 0);
    chk("rst_end", ifc.lsm_end, 0);
    chk("rst_abort", ifc.abort, 0);
    chk("rst_wb", ifc.wb_addr, 0);
    chk("rst_mar", ifc.mar_addr, 0);
    chk("rst_reg_sel", ifc.reg_sel, 0);
    reset = 1'b0;

    run(16'h0005, 1'b0, 1'b1, 32'h100, 0, 1'b0, 1'b0);          // IA
    run(16'h8003, 1'b1, 1'b0, 32'h200, 0, 1'b0, 1'b0);          // DB
    run(16'h0010, 1'b1, 1'b1, 32'h300, 0, 1'b0, 1'b0);          // IB
    run(16'h0010, 1'b0, 1'b0, 32'h300, 0, 1'b0, 1'b0);          // DA
    run(16'h0000, 1'b0, 1'b1, 32'h400, 0, 1'b0, 1'b0);          // empty list
    run(16'h0106, 1'b0, 1'b1, 32'h800, 3, 1'b0, 1'b0);          // MOC stalls
    run(16'h00F0, 1'b1, 1'b0, 32'h1000, 100, 1'b1, 1'b0);       // timeout abort
    run(16'h0A00, 1'b1, 1'b1, 32'h2000, 1, 1'b0, 1'b1);         // START mid-op
    run(16'h000F, 1'b0, 1'b1, 32'hFFFF_FFF8, 0, 1'b0, 1'b0);    // wrap up
    run(16'h0003, 1'b1, 1'b0, 32'h4, 0, 1'b0, 1'b0);            // wrap down
    run(16'hFFFF, 1'b0, 1'b0, 32'h1000, 0, 1'b0, 1'b0);         // full list

    // Reset while in ACCESS: transfer dropped, no LSM_END.
    stall = 100;
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.reg_list = 16'h0030; ifc.p = 1'b0; ifc.u = 1'b1; ifc.base = 32'h500;
    word_q.push_back('{r: 4'd4, a: 32'h500});
    @(posedge clk); #1;
    ifc.start = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_pre_mfa", ifc.mfa, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_mfa", ifc.mfa, 0);
    chk("rstmid_busy", ifc.busy, 0);
    chk("rstmid_end", ifc.lsm_end, 0);
    chk("rstmid_wb", ifc.wb_addr, 0);
    word_q.delete();
    repeat (6) @(posedge clk);
    #1;
    run(16'h0030, 1'b0, 1'b1, 32'h500, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run(16'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2), 1'b0, 1'b0);

    chk("sb_empty", word_q.size() + end_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Sequences ARM load/store-multiple (LDM/STM) transfers for the control unit.
- Started by the CU on an LSM instruction; walks the IR register list in ascending register order and computes each word address from the P/U addressing mode.
- Drives the memory handshake (MFA out, MOC in) once per word, and returns LSM_END plus the write-back base to the CU.
- Sits between the CU and the memory/register-file datapath.

Parameters:
- ADDR_W, 32, address/base width.
- MOC_TIMEOUT, 0, max ACCESS cycles waiting on MOC before abort; 0 disables the timeout.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request from CU; sampled only in IDLE.
- REG_LIST  input  16  IR[15:0]; bit i set = transfer Ri.
- P  input  1  IR[24]; 1 = pre-index (before), 0 = post (after).
- U  input  1  IR[23]; 1 = increment, 0 = decrement.
- BASE  input  ADDR_W  Rn value, sampled with START.
- MOC  input  1  memory operation complete.
- MFA  output  1  memory function activate.
- MAR_ADDR  output  ADDR_W  current word address.
- REG_SEL  output  4  register index for the current word.
- XFER  output  1  one-cycle pulse per completed word.
- BUSY  output  1  high from SETUP through DONE.
- LSM_END  output  1  one-cycle pulse at completion.
- ABORT  output  1  one-cycle pulse with LSM_END on timeout.
- WB_ADDR  output  ADDR_W  write-back base value; valid from SETUP, held until next START.

Behaviour:
- Reset: state IDLE, all outputs 0, internal list/counters 0. Applies mid-operation: the transfer is dropped and no LSM_END is issued.
- States: IDLE, SETUP, ACCESS, NEXT, DONE. All outputs are registered or decoded from state (Moore).
- IDLE:
  - START=1: latch REG_LIST, P, U, BASE, go to SETUP.
  - START is ignored in every other state.
- SETUP:
  - n = popcount(list), 0..16; offset = 4*n, computed at ADDR_W width, modulo 2^ADDR_W.
  - Start address: IA (P=0,U=1) BASE; IB (P=1,U=1) BASE+4; DA (P=0,U=0) BASE-offset+4; DB (P=1,U=0) BASE-offset.
  - WB_ADDR = U ? BASE+offset : BASE-offset.
  - n=0: go to DONE; no MFA, no XFER, WB_ADDR=BASE.
  - Otherwise go to ACCESS.
- ACCESS:
  - MFA=1; REG_SEL = index of lowest set bit of the remaining list; MAR_ADDR = current address.
  - MOC=1 sampled: go to NEXT.
  - Timeout: if MOC_TIMEOUT>0, the wait counter reaches MOC_TIMEOUT with MOC still 0 → go to DONE with the abort flag set.
- NEXT:
  - MFA=0, XFER=1; REG_SEL/MAR_ADDR hold the completed word.
  - Clear the lowest set bit; address += 4 (always ascending); wait counter cleared.
  - Remaining list empty → DONE, else ACCESS.
- DONE: LSM_END=1 for exactly one cycle; ABORT=1 in the same cycle if aborted; BUSY=1; then IDLE.
- Timing:
  - Cycle 0 = cycle START is high.
  - SETUP in cycle 1; first ACCESS in cycle 2.
  - With MOC tied high, each word takes 2 cycles, so LSM_END occurs in cycle 2+2n.
- MOC outside ACCESS is ignored.
- Address wrap past 2^ADDR_W-1 wraps silently.

Test Plan:
- IA: REG_LIST=0x0005, BASE=0x100, P=0,U=1, MOC=1 → ACCESS cycles 2 (REG_SEL 0, addr 0x100) and 4 (REG_SEL 2, addr 0x104); XFER in cycles 3 and 5; LSM_END in cycle 6; WB_ADDR=0x108.
- DB: REG_LIST=0x8003, BASE=0x200, P=1,U=0 → regs 0,1,15 at 0x1F4, 0x1F8, 0x1FC; WB_ADDR=0x1F4; LSM_END in cycle 8.
- IB REG_LIST=0x0010, BASE=0x300 → R4 at 0x304, WB 0x304. DA same list → R4 at 0x300, WB 0x2FC.
- Empty list: REG_LIST=0 → MFA never asserted, LSM_END in cycle 2, WB_ADDR=BASE.
- MOC stalls: MOC low 3 cycles per word with MOC_TIMEOUT=0 → MFA held, address stable, no XFER until MOC. With MOC_TIMEOUT=4 and MOC stuck low → exactly 4 ACCESS cycles, then LSM_END and ABORT pulse together, no XFER.
- START pulsed mid-operation → ignored. RESET in ACCESS → next cycle IDLE, MFA=BUSY=0, no LSM_END; a new START afterwards completes normally.
